// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC generation, variable-latency imem requests, in-order prefetch queue to decode.
// Latency: zero-wait memory gives request in cycle 0, response in cycle 1, out_valid in cycle 2, then one instruction per cycle.
// Backpressure: out_ready low holds the head stable; requests stop once queued plus outstanding reaches DEPTH.

// Generic synchronous FIFO with a synchronous flush. The head is read from registered storage.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: the caller guarantees a push never targets a full queue unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop_rdy,
  output logic                     head_vld,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  // Next-state for storage, pointers and occupancy; flush wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_rdy && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_vld) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_vld, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_vld = (count_q != '0);
  assign head_dat = head_vld ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

module fetch_stage #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic [CNT_W-1:0] q_count;
  logic [CNT_W:0]   inflight;
  logic             issue, resp, push, pop;
  logic             head_vld;
  entry_t           push_dat, head_dat;

  // Queue slots are reserved at request time, so a response always finds room.
  assign inflight = {1'b0, q_count} + {1'b0, outstanding_q};

  // Issue/response decisions and next PCs and counters; redirect overrides everything.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    issue         = rst_n && !redirect && (inflight < DEPTH_C);
    resp          = imem_valid && (outstanding_q != '0);
    pop           = head_vld && out_ready && !redirect;
    push          = resp && !redirect && (discard_q == '0);
    push_dat.pc    = resp_pc_q;
    push_dat.instr = imem_rdata;
    if (redirect) begin
      // Everything still in flight (minus a response landing now) becomes garbage.
      fetch_pc_d    = redirect_pc;
      resp_pc_d     = redirect_pc;
      outstanding_d = outstanding_q - CNT_W'(resp);
      discard_d     = outstanding_q - CNT_W'(resp);
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + PC_W'(1);
      end
      case ({issue, resp})
        2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
        2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
        default: outstanding_d = outstanding_q;
      endcase
      if (resp) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CNT_W'(1);
        end else begin
          resp_pc_d = resp_pc_q + PC_W'(1);
        end
      end
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= '0;
      resp_pc_q     <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  sync_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_prefetch_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .push_vld (push),
    .push_dat (push_dat),
    .pop_rdy  (pop),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (q_count)
  );

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign out_valid = head_vld;
  assign out_pc    = head_dat.pc;
  assign out_instr = head_dat.instr;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               out_ready;

  always #5 clk = ~clk;

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready)
  );

  typedef struct {
    logic [3:0]  pc;
    logic [15:0] instr;
  } ent_t;

  typedef struct {
    int         due;
    logic [3:0] addr;
  } req_t;

  // Reference model: prefetch queue, outstanding/discard counts, expected delivery stream.
  ent_t       mq[$];
  req_t       pipe[$];
  logic [3:0] dlog[$];
  int         m_out, m_disc;
  logic [3:0] m_fetch, m_resp, exp_next;
  int         cyc = 0;
  int         last_due = 0;
  int         lat_min = 1;
  int         lat_max = 1;
  bit         stray_en = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  logic        s_req, s_vld;
  logic [3:0]  s_pc;
  logic [15:0] s_instr;

  function automatic logic [15:0] mem_word(input logic [3:0] a);
    return 16'h1000 + {12'h000, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pipe.delete();
    m_out    = 0;
    m_disc   = 0;
    m_fetch  = '0;
    m_resp   = '0;
    exp_next = '0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_imem_req"},  32'(imem_req),  32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_pc"},    32'(out_pc),    32'd0);
    chk({tag, "_out_instr"}, 32'(out_instr), 32'd0);
  endtask

  // One clock cycle: drive inputs at negedge, compare at negedge+1, advance model for the coming posedge.
  task automatic step(input bit redir, input logic [3:0] rpc, input bit rdy, input bit force_stray);
    bit          mv, exp_req, resp;
    logic [15:0] md;
    ent_t        e;
    req_t        r;
    @(negedge clk);
    mv = 1'b0;
    md = '0;
    if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      mv = 1'b1;
      md = mem_word(pipe[0].addr);
      r  = pipe.pop_front();
    end else if (m_out == 0 && (force_stray || (stray_en && $urandom_range(0, 3) == 0))) begin
      mv = 1'b1;
      md = 16'($urandom);
    end
    imem_valid  = mv;
    imem_rdata  = md;
    redirect    = redir;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
    s_req   = imem_req;
    s_vld   = out_valid;
    s_pc    = out_pc;
    s_instr = out_instr;

    exp_req = (mq.size() + m_out < DEPTH) && !redir;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(m_fetch));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_pc",    32'(out_pc),    32'(mq[0].pc));
      chk("out_instr", 32'(out_instr), 32'(mq[0].instr));
    end
    if (out_valid === 1'b1 && rdy && !redir) begin
      chk("seq_pc",    32'(out_pc),    32'(exp_next));
      chk("seq_instr", 32'(out_instr), 32'(mem_word(exp_next)));
      dlog.push_back(out_pc);
      exp_next++;
    end

    resp = mv && (m_out > 0);
    if (redir) begin
      mq.delete();
      m_fetch = rpc;
      m_resp  = rpc;
      if (resp) m_out--;
      m_disc   = m_out;
      exp_next = rpc;
    end else begin
      if (mq.size() != 0 && rdy) e = mq.pop_front();
      if (resp) begin
        m_out--;
        if (m_disc > 0) begin
          m_disc--;
        end else begin
          e.pc    = m_resp;
          e.instr = md;
          mq.push_back(e);
          m_resp++;
        end
      end
      if (exp_req) begin
        m_out++;
        m_fetch++;
      end
    end
    if (exp_req) begin
      r.due  = cyc + $urandom_range(lat_min, lat_max);
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      r.addr   = imem_addr;
      pipe.push_back(r);
    end
    cyc++;
  endtask

  initial begin : main
    int n;
    imem_valid  = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    rst_n       = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk_outputs_zero("rst_async");
    repeat (3) @(negedge clk);
    #1 chk_outputs_zero("rst_held");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Zero-wait memory, no backpressure: startup latency and PC wrap.
    lat_min = 1; lat_max = 1;
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("lat_req_c0", 32'(s_req), 32'd1);
    chk("lat_vld_c0", 32'(s_vld), 32'd0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("lat_vld_c1", 32'(s_vld), 32'd0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("lat_vld_c2",   32'(s_vld),   32'd1);
    chk("lat_pc_c2",    32'(s_pc),    32'd0);
    chk("lat_instr_c2", 32'(s_instr), 32'h1000);
    repeat (20) step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("wrap_count", 32'(dlog.size()), 32'd21);
    chk("wrap_pc15",  32'(dlog[15]),    32'hF);
    chk("wrap_pc16",  32'(dlog[16]),    32'h0);

    // Redirect coinciding with a response and out_ready.
    n = dlog.size();
    step(1'b1, 4'h3, 1'b1, 1'b0);
    chk("redir_noreq", 32'(s_req), 32'd0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("redir_vld_next", 32'(s_vld), 32'd0);
    repeat (5) step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("redir_first_pc", 32'(dlog[n]), 32'h3);

    // Back-to-back redirects: the second one wins.
    step(1'b1, 4'h5, 1'b1, 1'b0);
    n = dlog.size();
    step(1'b1, 4'h9, 1'b1, 1'b0);
    repeat (6) step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("b2b_first_pc", 32'(dlog[n]), 32'h9);

    // Three-cycle memory, then redirect with three responses in flight.
    lat_min = 3; lat_max = 3;
    repeat (20) step(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && m_out != 3; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    n = dlog.size();
    step(1'b1, 4'hA, 1'b1, 1'b0);
    repeat (12) step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("redirA_pc0",    32'(dlog[n]),   32'hA);
    chk("redirA_pc1",    32'(dlog[n+1]), 32'hB);

    // Reset mid-stream with responses pending; stray responses afterwards.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("rst_mid");
    model_reset();
    repeat (3) begin
      @(negedge clk);
      imem_valid = 1'($urandom);
      imem_rdata = 16'($urandom);
      redirect   = 1'b0;
      #1 chk_outputs_zero("rst_mid_held");
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Backpressure after reset: queue fills to DEPTH, head holds pc 0.
    lat_min = 1; lat_max = 1;
    stray_en = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b1);
    repeat (10) step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("bp_req",   32'(s_req),   32'd0);
    chk("bp_vld",   32'(s_vld),   32'd1);
    chk("bp_pc",    32'(s_pc),    32'd0);
    chk("bp_instr", 32'(s_instr), 32'h1000);
    n = dlog.size();
    repeat (8) step(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) chk("bp_release_pc", 32'(dlog[n+i]), 32'(i));

    // Randomized traffic: variable latency, random backpressure, occasional redirects.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 3, 4'($urandom), $urandom_range(0, 9) < 7, 1'b0);
    end
    repeat (12) step(1'b0, 4'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that sits directly upstream of the decode register (IF/ID) in the 16-bit pipelined processor.
- Generates sequential PCs and issues requests to instruction memory, which may answer with variable latency.
- Buffers returned instructions with their PCs in a small in-order prefetch queue and hands them to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes the queue and discards in-flight responses.

Parameters:
- PC_W, 4, width of PC and instruction-memory address.
- INSTR_W, 16, instruction width.
- DEPTH, 4, prefetch queue entries (power of two, ≥2); also the cap on queued plus outstanding requests.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  request valid; memory accepts every asserted cycle.
- imem_addr  out  PC_W  request address (= fetch_pc).
- imem_valid  in  1  response valid; responses arrive in request order, at least 1 cycle after the request.
- imem_rdata  in  INSTR_W  response instruction.
- redirect  in  1  one-cycle pulse: flush and restart fetch.
- redirect_pc  in  PC_W  new fetch PC, sampled when redirect=1.
- out_valid  out  1  queue head valid toward decode.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  PC_W  head instruction's PC.
- out_ready  in  1  decode accepts head.

Behaviour:
- Reset (async assert, sync release): fetch_pc=0, resp_pc=0, queue count=0, outstanding=0, discard=0. Outputs imem_req=0, imem_addr=0, out_valid=0, out_instr=0, out_pc=0.
- State: fetch_pc (next address to request), resp_pc (PC of the next kept response), outstanding (requests issued, response not yet received), discard (responses still to drop), queue of {pc, instr}.
- Issue: imem_req = (count + outstanding < DEPTH) && !redirect. imem_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc+1, wrapping modulo 2^PC_W; outstanding++.
- Response (imem_valid=1, outstanding>0): outstanding--.
  - If discard>0: drop the response, discard--.
  - Else: push {resp_pc, imem_rdata}; resp_pc++ (wraps).
- imem_valid with outstanding==0 is ignored, with no state change.
- Output: out_valid = (count!=0); out_instr/out_pc are the head entry, driven from registered state only.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Head must hold stable while out_valid=1 and out_ready=0.
- Invariant: count + outstanding ≤ DEPTH at all times, so a push can never hit a full queue.
- Latency: with zero-wait memory (response the cycle after the request) and no backpressure:
  - reset release → first request in cycle 0, response in cycle 1, out_valid=1 in cycle 2;
  - one instruction per cycle thereafter.
- Redirect (highest priority), on the cycle redirect=1:
  - queue flushed (count=0); any pop that cycle is ignored;
  - no request issued;
  - fetch_pc <= redirect_pc; resp_pc <= redirect_pc;
  - any response arriving that cycle is dropped;
  - discard <= (outstanding − imem_valid) + (imem_valid ? 0 : 0), i.e. all still-outstanding responses are dropped. outstanding tracks the same count;
  - next cycle: out_valid=0 and issuing resumes at redirect_pc.
- Redirect while discard>0 from an earlier redirect: the new discard value is computed the same way, with no double counting.
- Back-to-back redirects: the last one wins.
- Reset mid-operation clears all state immediately. Late responses that then arrive with outstanding==0 are ignored.

Test Plan:
- Zero-wait memory returning mem[a]=16'h1000+a, out_ready=1 → out_pc sequence 0,1,2…15,0 (wrap), out_instr=16'h1000+pc, out_valid=1 from cycle 2 with no gaps.
- out_ready=0 for 10 cycles → exactly DEPTH=4 entries queued, imem_req=0, head stays pc=0 and stable. Release → pcs 0,1,2,3,4… in order, none lost or duplicated.
- 3-cycle memory latency, out_ready=1 → at most 4 outstanding, every PC delivered once and in order.
- Redirect to 4'hA with 3 responses in flight (latency 3) → those 3 are dropped, queue flushed. Next delivered out_pc sequence: A,B,C… with matching instructions.
- Redirect in the same cycle as imem_valid and out_ready=1 → the response is dropped, no pop reaches decode after flush, next out_pc = redirect_pc.
- rst_n pulsed low mid-stream with responses pending → outputs immediately 0. After release, fetch restarts at pc 0 and stray late imem_valid pulses are ignored.
